// File: rtl/jtag_dr_path.sv
`default_nettype none
// ============================================================================
// jtag_dr_path : JTAG IR + BYPASS/LOAD_PROGRAM/SCAN_TEST DR datapath, TDO mux.
// Optional IDCODE register enabled by defining JTAG_IDCODE_EN.   Rev 1.0
// ============================================================================
module jtag_dr_path #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
`ifdef JTAG_IDCODE_EN
   ,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
`endif
) (
   input  logic                  tck_i,
   input  logic                  trst_i,
   input  logic                  tdi_i,
   input  logic                  shiftIR_i,
   input  logic                  updateIR_i,
   input  logic                  shiftDR_i,
   input  logic                  updateDR_i,
   input  logic                  SelectIR_i,
   input  logic                  Enable_i,
   output logic                  tdo_o,
   output logic                  tdo_oe_o,
   output logic [3:0]            ir_o,
   output logic                  prog_we_o,
   output logic [ADDR_WIDTH-1:0] prog_addr_o,
   output logic [DATA_WIDTH-1:0] prog_data_o
);

   localparam int         LW         = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [3:0] IR_LOAD    = 4'b0001;
   localparam logic [3:0] IR_SCAN    = 4'b0010;
   localparam logic [3:0] IR_BYPASS  = 4'b0011;
   localparam logic [3:0] IR_CAPTURE = 4'b0001;
`ifdef JTAG_IDCODE_EN
   localparam logic [3:0] IR_IDCODE  = 4'b0100;
   localparam logic [3:0] IR_RESET   = IR_IDCODE;
`else
   localparam logic [3:0] IR_RESET   = IR_BYPASS;
`endif

   logic [3:0]            ir_sr_q, ir_sr_d, ir_q, ir_d;
   logic                  bypass_q, bypass_d;
   logic [LW-1:0]         load_q, load_d;
   logic [31:0]           scan_q, scan_d;
   logic [15:0]           word_cnt_q, word_cnt_d;
   logic                  prog_we_q, prog_we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  tdo_q, tdo_d, tdo_oe_q;
   logic                  sel_load, sel_scan, sel_byp, dr_shift, do_write, dr_lsb;
`ifdef JTAG_IDCODE_EN
   logic                  sel_id;
   logic [31:0]           idcode_q, idcode_d;
`endif

   always_comb begin
      sel_load = (ir_q == IR_LOAD);
      sel_scan = (ir_q == IR_SCAN);
`ifdef JTAG_IDCODE_EN
      sel_id   = (ir_q == IR_IDCODE);
      sel_byp  = !(sel_load || sel_scan || sel_id);
`else
      sel_byp  = !(sel_load || sel_scan);
`endif
      // An illegal shiftIR+shiftDR overlap leaves every DR untouched.
      dr_shift = shiftDR_i && !shiftIR_i;
      do_write = updateDR_i && sel_load;
   end

   always_comb begin
      ir_sr_d = shiftIR_i ? {tdi_i, ir_sr_q[3:1]} : IR_CAPTURE;
      ir_d    = updateIR_i ? ir_sr_q : ir_q;

      bypass_d = bypass_q;
      if (!shiftDR_i)
         bypass_d = 1'b0;
      else if (dr_shift && sel_byp)
         bypass_d = tdi_i;

      load_d = (dr_shift && sel_load) ? {tdi_i, load_q[LW-1:1]} : load_q;

      scan_d = scan_q;
      if (!shiftDR_i)
         scan_d = {16'h0000, word_cnt_q};
      else if (dr_shift && sel_scan)
         scan_d = {tdi_i, scan_q[31:1]};

`ifdef JTAG_IDCODE_EN
      idcode_d = idcode_q;
      if (!shiftDR_i)
         idcode_d = IDCODE_VALUE;
      else if (dr_shift && sel_id)
         idcode_d = {tdi_i, idcode_q[31:1]};
`endif

      prog_we_d  = do_write;
      addr_d     = do_write ? load_q[LW-1:DATA_WIDTH] : addr_q;
      data_d     = do_write ? load_q[DATA_WIDTH-1:0]  : data_q;
      word_cnt_d = (do_write && (word_cnt_q != 16'hFFFF)) ? word_cnt_q + 16'd1 : word_cnt_q;
   end

   always_comb begin
      dr_lsb = bypass_q;
      if (sel_load)
         dr_lsb = load_q[0];
      else if (sel_scan)
         dr_lsb = scan_q[0];
`ifdef JTAG_IDCODE_EN
      else if (sel_id)
         dr_lsb = idcode_q[0];
`endif
      tdo_d = Enable_i ? (SelectIR_i ? ir_sr_q[0] : dr_lsb) : 1'b0;
   end

   always_ff @(posedge tck_i or negedge trst_i) begin
      if (!trst_i) begin
         ir_sr_q    <= IR_CAPTURE;
         ir_q       <= IR_RESET;
         bypass_q   <= 1'b0;
         load_q     <= '0;
         scan_q     <= '0;
         word_cnt_q <= '0;
         prog_we_q  <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
`ifdef JTAG_IDCODE_EN
         idcode_q   <= '0;
`endif
      end else begin
         ir_sr_q    <= ir_sr_d;
         ir_q       <= ir_d;
         bypass_q   <= bypass_d;
         load_q     <= load_d;
         scan_q     <= scan_d;
         word_cnt_q <= word_cnt_d;
         prog_we_q  <= prog_we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
`ifdef JTAG_IDCODE_EN
         idcode_q   <= idcode_d;
`endif
      end
   end

   // TDO launches on the falling edge so the far end samples it on the next rise.
   always_ff @(negedge tck_i or negedge trst_i) begin
      if (!trst_i) begin
         tdo_q    <= 1'b0;
         tdo_oe_q <= 1'b0;
      end else begin
         tdo_q    <= tdo_d;
         tdo_oe_q <= Enable_i;
      end
   end

   assign tdo_o       = tdo_q;
   assign tdo_oe_o    = tdo_oe_q;
   assign ir_o        = ir_q;
   assign prog_we_o   = prog_we_q;
   assign prog_addr_o = addr_q;
   assign prog_data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_path.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_jtag_dr_path : self-checking bench for jtag_dr_path.   Rev 1.0
// ============================================================================
module tb_jtag_dr_path;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef JTAG_IDCODE_EN
   localparam logic [3:0] IR_RST = 4'b0100;
`else
   localparam logic [3:0] IR_RST = 4'b0011;
`endif

   logic          tck = 1'b0;
   logic          trst, tdi, shift_ir, update_ir, shift_dr, update_dr, sel_ir, enable;
   logic          tdo, tdo_oe, we;
   logic [3:0]    ir;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;

   int         checks = 0;
   int         errors = 0;
   logic       exp_tdo_q[$];
   logic [15:0] exp_cnt = 16'h0;

   typedef struct {
      logic [3:0] op;
      logic       exp_we;
      int         mode;   // 0 none, 1 bypass, 2 scan, 3 idcode
   } vec_t;
   vec_t tbl[7];

   jtag_dr_path dut (
      .tck_i      (tck),
      .trst_i     (trst),
      .tdi_i      (tdi),
      .shiftIR_i  (shift_ir),
      .updateIR_i (update_ir),
      .shiftDR_i  (shift_dr),
      .updateDR_i (update_dr),
      .SelectIR_i (sel_ir),
      .Enable_i   (enable),
      .tdo_o      (tdo),
      .tdo_oe_o   (tdo_oe),
      .ir_o       (ir),
      .prog_we_o  (we),
      .prog_addr_o(addr),
      .prog_data_o(data)
   );

   always #5 tck = ~tck;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cnt_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // One tck cycle starting/ending at posedge+1; TDO is scoreboarded at the negedge.
   task automatic cyc();
      logic e;
      @(negedge tck); #1;
      if (exp_tdo_q.size() > 0) begin
         e = exp_tdo_q.pop_front();
         chk("tdo", tdo, e);
      end
      @(posedge tck); #1;
   endtask

   task automatic load_ir(input logic [3:0] code, input logic chk_tdo);
      logic [3:0] cap;
      cap = 4'b0001;
      shift_ir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tdi = code[i];
         if (chk_tdo) exp_tdo_q.push_back(cap[i]);
         cyc();
      end
      shift_ir  = 1'b0;
      tdi       = 1'b0;
      update_ir = 1'b1;
      cyc();
      update_ir = 1'b0;
      chk("ir_o", ir, code);
   endtask

   task automatic shift_bits(input logic [63:0] bits, input int n, input logic [63:0] exp, input logic chk_en);
      shift_dr = 1'b1;
      for (int i = 0; i < n; i++) begin
         tdi = bits[i];
         if (chk_en) exp_tdo_q.push_back(exp[i]);
         cyc();
      end
      shift_dr = 1'b0;
      tdi      = 1'b0;
   endtask

   task automatic pulse_update(input logic exp_we);
      update_dr = 1'b1;
      cyc();
      chk("prog_we_o", we, exp_we);
      if (exp_we) exp_cnt = cnt_inc(exp_cnt);
      update_dr = 1'b0;
      cyc();
      chk("prog_we_clr", we, 1'b0);
   endtask

   initial begin
      trst = 1'b0; tdi = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
      shift_dr = 1'b0; update_dr = 1'b0; sel_ir = 1'b0; enable = 1'b0;

      tbl[0] = '{4'b0011, 1'b0, 1};
      tbl[1] = '{4'b0010, 1'b0, 2};
      tbl[2] = '{4'b0001, 1'b1, 0};
`ifdef JTAG_IDCODE_EN
      tbl[3] = '{4'b0100, 1'b0, 3};
`else
      tbl[3] = '{4'b0100, 1'b0, 1};
`endif
      tbl[4] = '{4'b0111, 1'b0, 1};
      tbl[5] = '{4'b1111, 1'b0, 1};
      tbl[6] = '{4'b0000, 1'b0, 1};

      // Reset values
      repeat (2) @(posedge tck);
      #1;
      chk("rst_ir", ir, IR_RST);
      chk("rst_we", we, 1'b0);
      chk("rst_addr", addr, 0);
      chk("rst_data", data, 0);
      chk("rst_tdo_oe", tdo_oe, 1'b0);
      chk("rst_tdo", tdo, 1'b0);
      trst   = 1'b1;
      enable = 1'b1;
      cyc();
      @(negedge tck); #1;
      chk("tdo_oe_en", tdo_oe, 1'b1);
      @(posedge tck); #1;

      // IR load with captured bits observed on TDO
      sel_ir = 1'b1;
      load_ir(4'b0001, 1'b1);
      sel_ir = 1'b0;

      // Program write: data first, then address
      shift_bits({32'h0000_0040, 32'hDEAD_BEEF}, 64, 64'h0, 1'b0);
      pulse_update(1'b1);
      chk("prog_addr", addr, 32'h40);
      chk("prog_data", data, 32'hDEAD_BEEF);

      // shiftIR+shiftDR together: DRs must hold
      shift_ir = 1'b1; shift_dr = 1'b1; tdi = 1'b0;
      repeat (4) cyc();
      shift_ir = 1'b0; shift_dr = 1'b0;
      cyc();
      shift_bits(64'h0, 32, {32'h0, 32'hDEAD_BEEF}, 1'b1);

      // Two more writes; register now holds {0, 0x40}
      pulse_update(1'b1);
      pulse_update(1'b1);
      chk("prog_addr2", addr, 32'h0);
      chk("prog_data2", data, 32'h40);

      // Scan counter
      load_ir(4'b0010, 1'b0);
      shift_bits(64'h0, 32, {48'h0, exp_cnt}, 1'b1);

      // Bypass: in 1,0,1,1 -> out 0,1,0,1
      load_ir(4'b0011, 1'b0);
      shift_bits(64'hD, 4, 64'hA, 1'b1);

      // Opcode decode table
      for (int k = 0; k < 7; k++) begin
         load_ir(tbl[k].op, 1'b0);
         pulse_update(tbl[k].exp_we);
         case (tbl[k].mode)
            1: shift_bits(64'h3, 2, 64'h2, 1'b1);
            2: shift_bits(64'h0, 2, {62'h0, exp_cnt[1:0]}, 1'b1);
            3: shift_bits(64'h0, 2, 64'h1, 1'b1);
            default: ;
         endcase
      end

      // Counter saturation; strobe still fires at 16'hFFFF
      load_ir(4'b0001, 1'b0);
      update_dr = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         @(posedge tck);
         exp_cnt = cnt_inc(exp_cnt);
      end
      #1;
      chk("we_held", we, 1'b1);
      update_dr = 1'b0;
      cyc();
      chk("we_drop", we, 1'b0);
      pulse_update(1'b1);
      load_ir(4'b0010, 1'b0);
      shift_bits(64'h0, 32, {48'h0, exp_cnt}, 1'b1);
      chk("cnt_model_sat", exp_cnt, 16'hFFFF);

      // Reset mid-operation cancels an in-flight strobe
      load_ir(4'b0001, 1'b0);
      shift_dr = 1'b1; tdi = 1'b1;
      repeat (3) cyc();
      shift_dr = 1'b0;
      update_dr = 1'b1;
      cyc();
      chk("we_before_rst", we, 1'b1);
      update_dr = 1'b0;
      #1 trst = 1'b0;
      #1;
      chk("rst_mid_we", we, 1'b0);
      chk("rst_mid_ir", ir, IR_RST);
      chk("rst_mid_addr", addr, 0);
      @(negedge tck); #1;
      chk("rst_mid_tdo_oe", tdo_oe, 1'b0);
      @(posedge tck); #1;
      trst = 1'b1;
      cyc();
      chk("post_rst_ir", ir, IR_RST);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtag_dr_path.md
# jtag_dr_path

JTAG instruction/data-register datapath that sits directly downstream of the TAP controller. It consumes the controller's shift/update/select/enable strobes, holds the 4-bit instruction register, and implements the BYPASS, LOAD_PROGRAM and SCAN_TEST data registers. It drives TDO and emits one-cycle program-memory write strobes toward the core-side loader.

## Interface
- `ADDR_WIDTH`, 32, program-memory address width.
- `DATA_WIDTH`, 32, program word width.
- `IDCODE_VALUE`, 32'h1000_0001, device ID; used only when `JTAG_IDCODE_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- `tck_i`  in  1  JTAG clock; the only clock.
- `trst_i`  in  1  asynchronous active-low reset.
- `tdi_i`  in  1  serial data in.
- `shiftIR_i`  in  1  TAP in SHIFT_IR.
- `updateIR_i`  in  1  TAP in UPDATE_IR.
- `shiftDR_i`  in  1  TAP in SHIFT_DR.
- `updateDR_i`  in  1  TAP in UPDATE_DR.
- `SelectIR_i`  in  1  1 selects the IR path for TDO, 0 selects the DR path.
- `Enable_i`  in  1  TDO output enable request.
- `tdo_o`  out  1  serial data out.
- `tdo_oe_o`  out  1  TDO driver enable.
- `ir_o`  out  4  active instruction.
- `prog_we_o`  out  1  program write strobe.
- `prog_addr_o`  out  ADDR_WIDTH  write address.
- `prog_data_o`  out  DATA_WIDTH  write data.

## Operation
- Instructions:
  - 4'b0001 LOAD_PROGRAM
  - 4'b0010 SCAN_TEST
  - 4'b0011 BYPASS
  - 4'b0100 IDCODE (macro only)
  - Any other code behaves as BYPASS.
- IR shift register `ir_sr` (4 bits):
  - When `shiftIR_i`=1: shifts right, `tdi_i` enters the MSB.
  - Otherwise it is preloaded with 4'b0001, the capture pattern.
- Active IR `ir_q`: loads `ir_sr` on any posedge with `updateIR_i`=1. `ir_o` = `ir_q`.
- DR selection follows `ir_q`. With `shiftDR_i`=1, only the selected DR shifts right with `tdi_i` into its MSB. Unselected DRs hold.
- BYPASS register (1 bit): cleared to 0 every cycle `shiftDR_i`=0.
- LOAD_PROGRAM register (ADDR_WIDTH+DATA_WIDTH bits):
  - Layout is {addr, data}, so data is shifted in first, LSB first.
  - Not recaptured; it holds its last contents.
- SCAN_TEST register (32 bits): when `shiftDR_i`=0, captures {16'h0, `word_cnt`}.
- `word_cnt` (16 bits): counts completed program writes and saturates at 16'hFFFF.
- Program write: on a posedge with `updateDR_i`=1 and `ir_q`=LOAD_PROGRAM:
  - `prog_addr_o` and `prog_data_o` load from the register.
  - `prog_we_o` goes to 1 and `word_cnt` increments.
  - On the next posedge `prog_we_o` returns to 0.
  - Address and data hold until the next write.
- TDO source:
  - `SelectIR_i`=1: `ir_sr[0]`.
  - Otherwise: LSB of the selected DR.
- Reset values: `ir_q` = BYPASS, `ir_sr` = 4'b0001, all DRs 0, `word_cnt` 0, `prog_we_o` 0, `prog_addr_o` 0, `prog_data_o` 0, `tdo_o` 0, `tdo_oe_o` 0.

## Timing
- All state changes on posedge `tck_i`, except `tdo_o` and `tdo_oe_o`.
- `tdo_o` and `tdo_oe_o` are registered on negedge `tck_i`:
  - `tdo_oe_o` <= `Enable_i`.
  - `tdo_o` <= selected LSB when `Enable_i`=1, else 0.
  - TDI is sampled on the rising edge and TDO changes on the falling edge.
- Latencies:
  - IR update: `ir_o` changes on the posedge on which `updateIR_i` is sampled high.
  - Program write: `prog_we_o` is high for exactly one `tck_i` cycle, starting at the posedge that samples `updateDR_i`.
- Boundary and simultaneous-event rules:
  - `updateDR_i` with a non-LOAD_PROGRAM instruction produces no strobe.
  - `shiftIR_i` and `shiftDR_i` both high is illegal; IR shift takes priority and the DRs hold.
  - `word_cnt` at 16'hFFFF stays at 16'hFFFF, but the write strobe still fires.
- Reset mid-operation: `trst_i` low asynchronously forces all reset values, including cancelling an in-flight `prog_we_o`.

## Configuration
- `JTAG_IDCODE_EN` defined:
  - Adds the IDCODE instruction with a 32-bit register that loads `IDCODE_VALUE` whenever `shiftDR_i`=0.
  - `ir_q` resets to IDCODE (4'b0100).
- `JTAG_IDCODE_EN` undefined:
  - No IDCODE register.
  - 4'b0100 decodes as BYPASS.
  - Reset `ir_q` = BYPASS.

## Test plan
- **Reset:** assert `trst_i`=0 mid-shift. Required: `ir_o`=4'b0011 (4'b0100 with macro), `prog_we_o`=0, and `tdo_oe_o`=0 at the next negedge.
- **IR load:** shift 4'b0001 LSB first, then pulse `updateIR_i`. Required: `ir_o`=4'b0001. TDO during the shift reads captured bits 1,0,0,0.
- **Program write:** in LOAD_PROGRAM, shift data 32'hDEAD_BEEF, then address 32'h0000_0040, then pulse `updateDR_i`. Required: one-cycle `prog_we_o`, `prog_addr_o`=32'h40, `prog_data_o`=32'hDEADBEEF.
- **Bypass:** in BYPASS, shift the pattern 1,0,1,1. Required: TDO returns a leading 0, then 1,0,1, delayed one cycle.
- **Scan counter:** after 3 program writes, select SCAN_TEST and shift 32 bits. Required: TDO yields 32'h0000_0003, LSB first.
- **Illegal opcode:** load IR 4'b1111. Required: behaves as BYPASS, and `updateDR_i` produces no `prog_we_o`.
